// File: rtl/teclado_filtro.sv
`default_nettype none
// ============================================================================
// Module   : teclado_filtro
// Purpose  : DigiLock keypad front-end: sync, debounce, multi-key rejection,
//            4-digit BCD code assembly with pronto/consumido handshake.
// Revision : 1.0  initial release
// ============================================================================
module teclado_filtro #(
    parameter int DEBOUNCE = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [9:0]  codificador,
    input  logic        consumido,
    output logic [3:0]  digito,
    output logic        tecla_valida,
    output logic        erro_multi,
    output logic [15:0] codigo,
    output logic [2:0]  n_digitos,
    output logic        pronto,
    output logic        descartado
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE - 1);

    localparam logic [1:0] c_ocioso      = 2'd0;
    localparam logic [1:0] c_filtrando   = 2'd1;
    localparam logic [1:0] c_pressionado = 2'd2;
    localparam logic [1:0] c_soltando    = 2'd3;

    logic [9:0]    r_sync1;
    logic [9:0]    r_amostra;
    logic [1:0]    r_state;
    logic [9:0]    r_cand;
    logic [CW-1:0] r_cnt;

    logic [1:0]    w_state_nxt;
    logic [9:0]    w_cand_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;
    logic          w_one_hot;
    logic [3:0]    w_index;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_amostra <= '0;
        end else begin
            r_sync1   <= codificador;
            r_amostra <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ocioso;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            c_ocioso: begin
                if (r_amostra != 10'd0) begin
                    w_cand_nxt  = r_amostra;
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = c_filtrando;
                end
            end
            c_filtrando: begin
                if (r_amostra == 10'd0) begin
                    w_state_nxt = c_ocioso;
                end else if (r_amostra != r_cand) begin
                    w_cand_nxt = r_amostra;
                    w_cnt_nxt  = c_cnt_one;
                end else if (r_cnt == c_cnt_last) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_pressionado;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            c_pressionado: begin
                if (r_amostra == 10'd0) begin
                    w_cnt_nxt   = c_cnt_one;
                    w_state_nxt = c_soltando;
                end
            end
            c_soltando: begin
                if (r_amostra != 10'd0) begin
                    w_state_nxt = c_pressionado;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_ocioso;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: w_state_nxt = c_ocioso;
        endcase
    end

    // cand is never zero when an accept happens, so this only separates 1 bit from >=2
    assign w_one_hot = ((r_cand & (r_cand - 10'd1)) == 10'd0);

    always_comb begin
        w_index = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_cand[i]) begin
                w_index = 4'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digito       <= '0;
            tecla_valida <= 1'b0;
            erro_multi   <= 1'b0;
        end else begin
            tecla_valida <= w_accept && w_one_hot;
            erro_multi   <= w_accept && !w_one_hot;
            if (w_accept && w_one_hot) begin
                digito <= w_index;
            end
        end
    end

    // Consume takes priority over a digit arriving while the code is full
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            codigo     <= '0;
            n_digitos  <= '0;
            pronto     <= 1'b0;
            descartado <= 1'b0;
        end else begin
            descartado <= tecla_valida && pronto;
            if (pronto && consumido) begin
                pronto    <= 1'b0;
                codigo    <= '0;
                n_digitos <= '0;
            end else if (tecla_valida && !pronto) begin
                codigo    <= {codigo[11:0], digito};
                n_digitos <= n_digitos + 3'd1;
                if (n_digitos == 3'd3) begin
                    pronto <= 1'b1;
                end
            end else if (erro_multi && !pronto) begin
                codigo    <= '0;
                n_digitos <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_teclado_filtro.sv
`default_nettype none
// ============================================================================
// Module   : tb_teclado_filtro
// Purpose  : Directed bench for teclado_filtro with a sliding-window model.
// Revision : 1.0  initial release
// ============================================================================
module tb_teclado_filtro;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  codificador = '0;
    logic        consumido = 1'b0;
    logic [3:0]  digito;
    logic        tecla_valida;
    logic        erro_multi;
    logic [15:0] codigo;
    logic [2:0]  n_digitos;
    logic        pronto;
    logic        descartado;

    teclado_filtro #(.DEBOUNCE(D)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .codificador  (codificador),
        .consumido    (consumido),
        .digito       (digito),
        .tecla_valida (tecla_valida),
        .erro_multi   (erro_multi),
        .codigo       (codigo),
        .n_digitos    (n_digitos),
        .pronto       (pronto),
        .descartado   (descartado)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int n_tv = 0;
    int n_em = 0;
    int n_desc = 0;

    // Model state: the two-edge input delay, the last D synchronised samples,
    // whether a key is currently considered held, and the visible outputs.
    logic [9:0]  m_d1 = '0;
    logic [9:0]  m_d2 = '0;
    logic [9:0]  m_hist [D];
    logic        m_held = 1'b0;
    logic [3:0]  m_dig = '0;
    logic        m_tv = 1'b0;
    logic        m_em = 1'b0;
    logic        m_desc = 1'b0;
    logic        m_pronto = 1'b0;
    logic [15:0] m_cod = '0;
    logic [2:0]  m_n = '0;

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_held = 1'b0;
        for (int i = 0; i < D; i++) m_hist[i] = '0;
        m_dig = '0; m_tv = 1'b0; m_em = 1'b0; m_desc = 1'b0;
        m_pronto = 1'b0; m_cod = '0; m_n = '0;
    endtask

    // Inputs are stable from one negedge to the next, so the values seen here
    // are exactly what the preceding rising edge sampled.
    task automatic model_update();
        logic [9:0] s;
        logic       same;
        logic       new_desc;
        if (!reset_n) begin
            model_clear();
            return;
        end
        new_desc = m_tv && m_pronto;
        if (m_pronto && consumido) begin
            m_pronto = 1'b0; m_cod = '0; m_n = '0;
        end else if (m_tv && !m_pronto) begin
            m_cod = (m_cod << 4) | 16'(m_dig);
            m_n = m_n + 3'd1;
            if (m_n == 3'd4) m_pronto = 1'b1;
        end else if (m_em && !m_pronto) begin
            m_cod = '0; m_n = '0;
        end
        m_desc = new_desc;

        s = m_d2; m_d2 = m_d1; m_d1 = codificador;
        for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = s;
        same = 1'b1;
        for (int i = 1; i < D; i++) if (m_hist[i] != m_hist[0]) same = 1'b0;

        m_tv = 1'b0; m_em = 1'b0;
        if (!m_held && same && m_hist[0] != 10'd0) begin
            m_held = 1'b1;
            if ($countones(m_hist[0]) == 1) begin
                m_tv = 1'b1;
                for (int i = 0; i < 10; i++) if (m_hist[0][i]) m_dig = 4'(i);
            end else begin
                m_em = 1'b1;
            end
        end else if (m_held && same && m_hist[0] == 10'd0) begin
            m_held = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [26:0] dut_bus();
        return {digito, tecla_valida, erro_multi, codigo, n_digitos, pronto, descartado};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            model_update();
            n_tv   += int'(tecla_valida);
            n_em   += int'(erro_multi);
            n_desc += int'(descartado);
            check("model_cmp", 32'(dut_bus()),
                  32'({m_dig, m_tv, m_em, m_cod, m_n, m_pronto, m_desc}));
        end
    endtask

    task automatic press(input logic [9:0] k, input int hold, input int rel);
        codificador = k;
        step(hold);
        codificador = '0;
        step(rel);
    endtask

    int t0;
    int e0;
    int d0;

    initial begin
        model_clear();
        step(3);
        check("reset_outputs", 32'(dut_bus()), 32'd0);
        reset_n = 1'b1;
        step(2);

        // Normal entry 0, 2, 7, 5
        t0 = n_tv;
        press(10'h001, 8, 8);
        press(10'h004, 8, 8);
        press(10'h080, 8, 8);
        press(10'h020, 8, 8);
        check("entry_pulses", 32'(n_tv - t0), 32'd4);
        check("entry_codigo", 32'(codigo), 32'h0275);
        check("entry_n", 32'(n_digitos), 32'd4);
        check("entry_pronto", 32'(pronto), 32'd1);
        check("entry_digito", 32'(digito), 32'd5);

        // Overflow: digit 9 dropped
        d0 = n_desc;
        press(10'h200, 8, 8);
        check("ovf_desc", 32'(n_desc - d0), 32'd1);
        check("ovf_codigo", 32'(codigo), 32'h0275);
        check("ovf_pronto", 32'(pronto), 32'd1);

        // Overflow with consume in the tecla_valida cycle
        d0 = n_desc;
        codificador = 10'h200;
        step(6);
        check("ovf2_tv_cycle", 32'(tecla_valida), 32'd1);
        consumido = 1'b1;
        step(1);
        consumido = 1'b0;
        check("ovf2_pronto", 32'(pronto), 32'd0);
        check("ovf2_codigo", 32'(codigo), 32'd0);
        check("ovf2_n", 32'(n_digitos), 32'd0);
        step(7);
        codificador = '0;
        step(8);
        check("ovf2_desc", 32'(n_desc - d0), 32'd1);

        // Bounce on bit 3, then steady
        t0 = n_tv;
        for (int i = 0; i < 5; i++) begin
            codificador = (i % 2 == 0) ? 10'h008 : 10'h000;
            step(2);
        end
        press(10'h008, 8, 8);
        check("bounce_pulses", 32'(n_tv - t0), 32'd1);
        check("bounce_digito", 32'(digito), 32'd3);
        check("bounce_codigo", 32'(codigo), 32'h0003);

        // Short glitch on bit 6
        t0 = n_tv; e0 = n_em;
        press(10'h040, 3, 8);
        check("glitch_pulses", 32'(n_tv - t0 + n_em - e0), 32'd0);

        // Multi-key aborts partial entry
        press(10'h002, 8, 8);
        press(10'h004, 8, 8);
        check("multi_pre_n", 32'(n_digitos), 32'd3);
        t0 = n_tv; e0 = n_em;
        press(10'h012, 8, 8);
        check("multi_em", 32'(n_em - e0), 32'd1);
        check("multi_tv", 32'(n_tv - t0), 32'd0);
        check("multi_codigo", 32'(codigo), 32'd0);
        check("multi_n", 32'(n_digitos), 32'd0);

        // Asynchronous reset while filtering bit 3
        press(10'h002, 8, 8);
        press(10'h004, 8, 8);
        codificador = 10'h008;
        step(3);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 32'(dut_bus()), 32'd0);
        step(2);
        reset_n = 1'b1;
        t0 = n_tv;
        step(10);
        codificador = '0;
        step(8);
        check("post_reset_pulses", 32'(n_tv - t0), 32'd1);
        check("post_reset_digito", 32'(digito), 32'd3);
        check("post_reset_codigo", 32'(codigo), 32'h0003);

        // consumido while not ready is ignored
        consumido = 1'b1;
        step(1);
        consumido = 1'b0;
        step(1);
        check("idle_consume_n", 32'(n_digitos), 32'd1);

        // Long hold, then change key without release
        t0 = n_tv;
        codificador = 10'h100;
        step(50);
        check("hold_pulses", 32'(n_tv - t0), 32'd1);
        codificador = 10'h200;
        step(20);
        check("hold_change_pulses", 32'(n_tv - t0), 32'd1);
        check("hold_digito", 32'(digito), 32'd8);
        codificador = '0;
        step(8);

        // Complete a code and consume it
        press(10'h002, 8, 8);
        press(10'h010, 8, 8);
        check("full_codigo", 32'(codigo), 32'h3814);
        check("full_pronto", 32'(pronto), 32'd1);
        consumido = 1'b1;
        step(1);
        consumido = 1'b0;
        check("consume_pronto", 32'(pronto), 32'd0);
        check("consume_codigo", 32'(codigo), 32'd0);
        check("consume_n", 32'(n_digitos), 32'd0);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
